// File: rtl/multicore_debug_pkg.sv
// Shared definitions for the multicore debug halt controller.
//   - FSM state encodings (IDLE=0, HALTING=1, HALTED=2, RESUMING=3)
//   - ACK_CNT_W : width of the ack wait counter
//   - MAX_CORES : upper bound on the number of controlled cores
//   - lowest_set(): index of the lowest set bit of a core vector
package multicore_debug_pkg;

  localparam int ACK_CNT_W = 8;
  localparam int MAX_CORES = 8;
  localparam int MAX_IDX_W = 3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HALTING  = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;
  localparam logic [1:0] ST_RESUMING = 2'd3;

  // Scan from the top down so the last hit written is the lowest index.
  function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [MAX_CORES-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (vec[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/multicore_debug_ack_timer.sv
// Saturating wait counter used while the controller waits for debugack
// edges (both the halt wait and the resume wait).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear (has priority over en)
//   en           : count one cycle
//   done         : high during the ACK_TIMEOUT-th enabled cycle since clear
module multicore_debug_ack_timer
  import multicore_debug_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [ACK_CNT_W-1:0] LIMIT   = ACK_CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [ACK_CNT_W-1:0] CNT_MAX = '1;

  logic [ACK_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q holds the number of enabled cycles already elapsed, so the
  // current cycle is the ACK_TIMEOUT-th one when cnt_q == ACK_TIMEOUT-1.
  assign done = en && (cnt_q >= LIMIT);

endmodule

// File: rtl/multicore_debug_halt_ctrl.sv
// Halts and resumes all participating Nios II cores as one unit.
// A halt starts from a host break pulse or, when cfg_sync_en is set, from
// any participating core raising its own debugack. The controller then
// holds debugreq on every participating core and waits for all of their
// debugacks, reporting a single halted state, the halt cause and a sticky
// timeout error.
//
// Request/ack protocol with the cores: core_debugreq is a level that stays
// high from the cycle after a halt is accepted until the cycle after a
// resume is accepted; a core signals "halted" by holding core_debugack high
// and "running" by dropping it. Acks from cores outside the latched mask
// are never looked at. host_halt_req / host_resume_req are single-cycle
// pulses that are acted on only in the states where they make sense and
// are otherwise dropped.
//
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   host_halt_req    : host break pulse
//   host_resume_req  : host resume pulse
//   cfg_sync_en      : a core self-halt halts everyone
//   cfg_core_mask    : participating cores, latched when a halt starts
//   core_debugack    : per-core debugack level
//   core_debugreq    : per-core debugreq level
//   all_halted       : every latched core is acking
//   busy             : halt or resume in progress
//   halt_cause_host  : last halt came from the host
//   halt_cause_core  : lowest core whose self-ack started the last halt
//   timeout_err      : sticky ack timeout
//   dbg_state        : current FSM state
module multicore_debug_halt_ctrl
  import multicore_debug_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int CIDX_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 host_halt_req,
  input  logic                 host_resume_req,
  input  logic                 cfg_sync_en,
  input  logic [NUM_CORES-1:0] cfg_core_mask,
  input  logic [NUM_CORES-1:0] core_debugack,
  output logic [NUM_CORES-1:0] core_debugreq,
  output logic                 all_halted,
  output logic                 busy,
  output logic                 halt_cause_host,
  output logic [CIDX_W-1:0]    halt_cause_core,
  output logic                 timeout_err,
  output logic [1:0]           dbg_state
);

  logic [1:0]           state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_CORES-1:0] debugreq_q, debugreq_d;
  logic                 all_halted_q, all_halted_d;
  logic                 busy_q, busy_d;
  logic                 cause_host_q, cause_host_d;
  logic [CIDX_W-1:0]    cause_core_q, cause_core_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_CORES-1:0] acks;
  logic [NUM_CORES-1:0] self_hits;
  logic [MAX_CORES-1:0] self_hits_ext;
  logic                 waiting;
  logic                 tmr_done;

  assign acks          = core_debugack & mask_q;
  // In IDLE the mask is not latched yet, so self-halt detection uses the
  // live configuration.
  assign self_hits     = core_debugack & cfg_core_mask;
  assign self_hits_ext = MAX_CORES'(self_hits);

  // The only transitions between wait states pass through HALTED or IDLE,
  // so holding the timer clear outside the wait states is enough to start
  // every wait from zero.
  assign waiting = (state_q == ST_HALTING) || (state_q == ST_RESUMING);

  multicore_debug_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!waiting),
    .en      (waiting),
    .done    (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    cause_host_d = cause_host_q;
    cause_core_d = cause_core_q;
    timeout_d    = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (host_halt_req) begin
          // Host wins the cause even if a core self-acks in the same cycle.
          state_d      = ST_HALTING;
          mask_d       = cfg_core_mask;
          cause_host_d = 1'b1;
          cause_core_d = '0;
          timeout_d    = 1'b0;
        end else if (cfg_sync_en && (|self_hits)) begin
          state_d      = ST_HALTING;
          mask_d       = cfg_core_mask;
          cause_host_d = 1'b0;
          cause_core_d = CIDX_W'(lowest_set(self_hits_ext));
        end
      end
      ST_HALTING: begin
        // An empty mask matches immediately and halts in one cycle.
        if (acks == mask_q) begin
          state_d = ST_HALTED;
        end else if (tmr_done) begin
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end
      end
      ST_HALTED: begin
        if (host_resume_req) begin
          state_d = ST_RESUMING;
        end
      end
      ST_RESUMING: begin
        if (acks == '0) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Debug requests stay on through a partial (timed-out) halt as well.
    debugreq_d   = ((state_d == ST_HALTING) || (state_d == ST_HALTED)) ? mask_d : '0;
    all_halted_d = (state_d == ST_HALTED) && (acks == mask_d);
    busy_d       = (state_d == ST_HALTING) || (state_d == ST_RESUMING);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      debugreq_q   <= '0;
      all_halted_q <= 1'b0;
      busy_q       <= 1'b0;
      cause_host_q <= 1'b0;
      cause_core_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      debugreq_q   <= debugreq_d;
      all_halted_q <= all_halted_d;
      busy_q       <= busy_d;
      cause_host_q <= cause_host_d;
      cause_core_q <= cause_core_d;
      timeout_q    <= timeout_d;
    end
  end

  assign core_debugreq   = debugreq_q;
  assign all_halted      = all_halted_q;
  assign busy            = busy_q;
  assign halt_cause_host = cause_host_q;
  assign halt_cause_core = cause_core_q;
  assign timeout_err     = timeout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_multicore_debug_halt_ctrl.sv
module tb_multicore_debug_halt_ctrl;

  localparam int NC = 4;
  localparam int TO = 16;
  localparam int CW = 3;
  localparam int W  = 13;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HING = 2'd1;
  localparam logic [1:0] S_HED  = 2'd2;
  localparam logic [1:0] S_RES  = 2'd3;

  logic          clk;
  logic          reset_n;
  logic          host_halt_req;
  logic          host_resume_req;
  logic          cfg_sync_en;
  logic [NC-1:0] cfg_core_mask;
  logic [NC-1:0] core_debugack;
  logic [NC-1:0] core_debugreq;
  logic          all_halted;
  logic          busy;
  logic          halt_cause_host;
  logic [CW-1:0] halt_cause_core;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  int vectors;
  int miscompares;
  int n;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;

  multicore_debug_halt_ctrl #(
    .NUM_CORES   (NC),
    .ACK_TIMEOUT (TO),
    .CIDX_W      (CW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .host_halt_req   (host_halt_req),
    .host_resume_req (host_resume_req),
    .cfg_sync_en     (cfg_sync_en),
    .cfg_core_mask   (cfg_core_mask),
    .core_debugack   (core_debugack),
    .core_debugreq   (core_debugreq),
    .all_halted      (all_halted),
    .busy            (busy),
    .halt_cause_host (halt_cause_host),
    .halt_cause_core (halt_cause_core),
    .timeout_err     (timeout_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {dbg_state, core_debugreq, all_halted, busy,
                halt_cause_host, halt_cause_core, timeout_err};

  function automatic logic [W-1:0] vec(input logic [1:0] st, input logic [NC-1:0] rq,
                                       input logic ah, input logic bz, input logic ch,
                                       input logic [CW-1:0] cc, input logic te);
    return {st, rq, ah, bz, ch, cc, te};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Inputs for the next edge are already driven; push what the outputs
  // must be after that edge, then pop and compare once it has happened.
  task automatic step(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] e;
    exp_q.push_back(exp);
    tick();
    e = exp_q.pop_front();
    chk(tag, 32'(obs), 32'(e));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NC-1:0] ack_tab [1:6];
    vectors         = 0;
    miscompares     = 0;
    reset_n         = 1'b0;
    host_halt_req   = 1'b0;
    host_resume_req = 1'b0;
    cfg_sync_en     = 1'b0;
    cfg_core_mask   = 4'b1111;
    core_debugack   = 4'b0000;

    #3;
    chk("reset_outputs", 32'(obs), 32'(vec(S_IDLE, 4'b0000, 0, 0, 0, 3'd0, 0)));
    @(negedge clk);
    reset_n = 1'b1;
    step("idle_after_reset", vec(S_IDLE, 4'b0000, 0, 0, 0, 3'd0, 0));

    // Host halt, acks rising at cycles 2,3,5,6; a resume in HALTING is ignored.
    ack_tab[1] = 4'b0000; ack_tab[2] = 4'b0001; ack_tab[3] = 4'b0011;
    ack_tab[4] = 4'b0011; ack_tab[5] = 4'b0111; ack_tab[6] = 4'b1111;
    host_halt_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      if (c < 7) step($sformatf("host_halt_c%0d", c), vec(S_HING, 4'b1111, 0, 1, 1, 3'd0, 0));
      else       step("host_halt_done", vec(S_HED, 4'b1111, 1, 0, 1, 3'd0, 0));
      host_halt_req   = 1'b0;
      host_resume_req = (c == 3);
      if (c < 7) core_debugack = ack_tab[c];
    end
    host_resume_req = 1'b1;
    step("resume_enter", vec(S_RES, 4'b0000, 0, 1, 1, 3'd0, 0));
    host_resume_req = 1'b0;
    core_debugack   = 4'b0000;
    step("resume_idle", vec(S_IDLE, 4'b0000, 0, 0, 1, 3'd0, 0));

    // Timeout: mask 0011, only core 0 acks.
    cfg_core_mask = 4'b0011;
    core_debugack = 4'b0001;
    host_halt_req = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      host_halt_req = 1'b0;
      if (dbg_state == S_HING) n++;
      else break;
    end
    chk("halting_cycles", 32'(n), 32'(TO));
    chk("halt_timeout", 32'(obs), 32'(vec(S_HED, 4'b0011, 0, 0, 1, 3'd0, 1)));
    cfg_core_mask = 4'b1111;
    host_halt_req = 1'b1;
    step("halted_ignores_halt_and_mask", vec(S_HED, 4'b0011, 0, 0, 1, 3'd0, 1));
    host_halt_req = 1'b0;
    core_debugack = 4'b0011;
    step("halted_tracks_acks", vec(S_HED, 4'b0011, 1, 0, 1, 3'd0, 1));
    core_debugack = 4'b1111;
    step("unmasked_acks_ignored", vec(S_HED, 4'b0011, 1, 0, 1, 3'd0, 1));
    core_debugack = 4'b0011;
    step("halted_stays", vec(S_HED, 4'b0011, 1, 0, 1, 3'd0, 1));
    host_resume_req = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      host_resume_req = 1'b0;
      host_halt_req   = (i == 5);
      if (dbg_state == S_RES) n++;
      else break;
    end
    host_halt_req = 1'b0;
    chk("resuming_cycles", 32'(n), 32'(TO));
    chk("resume_timeout", 32'(obs), 32'(vec(S_IDLE, 4'b0000, 0, 0, 1, 3'd0, 1)));

    // Empty mask host halt; also clears the sticky error.
    core_debugack = 4'b0000;
    cfg_core_mask = 4'b0000;
    host_halt_req = 1'b1;
    step("empty_mask_halting", vec(S_HING, 4'b0000, 0, 1, 1, 3'd0, 0));
    host_halt_req = 1'b0;
    step("empty_mask_halted", vec(S_HED, 4'b0000, 1, 0, 1, 3'd0, 0));
    host_resume_req = 1'b1;
    step("empty_mask_resume", vec(S_RES, 4'b0000, 0, 1, 1, 3'd0, 0));
    host_resume_req = 1'b0;
    step("empty_mask_idle", vec(S_IDLE, 4'b0000, 0, 0, 1, 3'd0, 0));

    // Host halt and core 1 self-ack together: host wins the cause.
    cfg_core_mask = 4'b1111;
    cfg_sync_en   = 1'b1;
    core_debugack = 4'b0010;
    host_halt_req = 1'b1;
    step("simul_cause_host", vec(S_HING, 4'b1111, 0, 1, 1, 3'd0, 0));
    host_halt_req = 1'b0;
    core_debugack = 4'b1111;
    step("simul_halted", vec(S_HED, 4'b1111, 1, 0, 1, 3'd0, 0));
    host_resume_req = 1'b1;
    core_debugack   = 4'b0000;
    step("simul_resume", vec(S_RES, 4'b0000, 0, 1, 1, 3'd0, 0));
    host_resume_req = 1'b0;
    step("simul_idle", vec(S_IDLE, 4'b0000, 0, 0, 1, 3'd0, 0));

    // Self-ack from an unmasked core, plus a resume in IDLE: nothing happens.
    cfg_core_mask   = 4'b1101;
    core_debugack   = 4'b0010;
    host_resume_req = 1'b1;
    step("unmasked_self_ack", vec(S_IDLE, 4'b0000, 0, 0, 1, 3'd0, 0));
    host_resume_req = 1'b0;
    step("unmasked_self_ack2", vec(S_IDLE, 4'b0000, 0, 0, 1, 3'd0, 0));

    // Sync self-halt from core 2, first with sync disabled.
    cfg_core_mask = 4'b1111;
    cfg_sync_en   = 1'b0;
    core_debugack = 4'b0100;
    step("sync_off_no_halt", vec(S_IDLE, 4'b0000, 0, 0, 1, 3'd0, 0));
    cfg_sync_en = 1'b1;
    step("sync_self_halt", vec(S_HING, 4'b1111, 0, 1, 0, 3'd2, 0));
    core_debugack = 4'b1111;
    step("sync_halted", vec(S_HED, 4'b1111, 1, 0, 0, 3'd2, 0));
    host_resume_req = 1'b1;
    core_debugack   = 4'b0000;
    step("sync_resume", vec(S_RES, 4'b0000, 0, 1, 0, 3'd2, 0));
    host_resume_req = 1'b0;
    step("sync_idle", vec(S_IDLE, 4'b0000, 0, 0, 0, 3'd2, 0));

    // Asynchronous reset in the middle of HALTING.
    core_debugack = 4'b0001;
    step("pre_reset_halting", vec(S_HING, 4'b1111, 0, 1, 0, 3'd0, 0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 32'(obs), 32'(vec(S_IDLE, 4'b0000, 0, 0, 0, 3'd0, 0)));
    @(negedge clk);
    core_debugack = 4'b0000;
    cfg_sync_en   = 1'b0;
    reset_n       = 1'b1;
    step("idle_after_release", vec(S_IDLE, 4'b0000, 0, 0, 0, 3'd0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicore_debug_halt_ctrl.md
Name: multicore_debug_halt_ctrl

Overview:
- Sysclk-domain controller that halts and resumes all Nios II cores of the multicore Sobel system as one unit.
- Sources of a halt:
  - a host break command from the JTAG debug module's sysclk side;
  - any enabled core's own breakpoint/debugack.
- Drives every core's debugreq, tracks per-core debugack, and reports a single coherent halted state, halt cause and timeout error back to the debug path.

Parameters:
- NUM_CORES, 4, number of cores under control (2..8).
- ACK_TIMEOUT, 255, max clk cycles to wait for all acks before flagging error (1..255, 8-bit counter).
- CIDX_W, 3, width of core index fields (must satisfy 2**CIDX_W >= NUM_CORES).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- host_halt_req  in  1  one-cycle pulse, host requests halt of all enabled cores.
- host_resume_req  in  1  one-cycle pulse, host requests resume.
- cfg_sync_en  in  1  1: a self-halt of one core halts all; 0: only host halts propagate.
- cfg_core_mask  in  NUM_CORES  1 = core participates; sampled only in IDLE.
- core_debugack  in  NUM_CORES  per-core debugack, level.
- core_debugreq  out  NUM_CORES  per-core debug request, level.
- all_halted  out  1  all masked cores acked.
- busy  out  1  in HALTING or RESUMING.
- halt_cause_host  out  1  last halt was host-initiated.
- halt_cause_core  out  CIDX_W  index of lowest core whose self-ack triggered the halt.
- timeout_err  out  1  sticky; cleared by next host_halt_req or reset.

Behaviour:
- Reset (async, reset_n low): all outputs 0, state IDLE, latched mask 0, timeout counter 0.
- States: IDLE, HALTING, HALTED, RESUMING.
- Definitions:
  - mask_q: cfg_core_mask latched on the IDLE->HALTING transition.
  - acks = core_debugack & mask_q.
- IDLE:
  - host_halt_req: next cycle state HALTING, core_debugreq = cfg_core_mask, halt_cause_host = 1, timeout_err cleared.
  - Else, cfg_sync_en = 1 and any (core_debugack & cfg_core_mask) bit set: HALTING, halt_cause_host = 0, halt_cause_core = lowest such index.
  - If both happen in the same cycle, host wins for cause.
- HALTING:
  - Counter increments each cycle.
  - acks == mask_q: next cycle HALTED, all_halted = 1, counter cleared.
  - Counter reaches ACK_TIMEOUT first: timeout_err = 1, state HALTED, all_halted = 0 (partial halt), debugreq kept asserted.
- HALTED:
  - debugreq held.
  - all_halted tracks (acks == mask_q) each cycle.
  - host_resume_req: next cycle RESUMING, core_debugreq = 0, counter cleared.
  - host_halt_req is ignored; timeout_err is not cleared.
- RESUMING:
  - Wait for acks == 0, then IDLE next cycle; all_halted drops on entry.
  - On timeout: timeout_err = 1, IDLE anyway.
- host_resume_req in IDLE or HALTING is ignored.
- host_halt_req in RESUMING is ignored.
- busy = state is HALTING or RESUMING (registered).
- mask_q == 0 on a host halt: HALTING completes in 1 cycle (acks == mask_q trivially), all_halted = 1.
- Latency: req pulse to debugreq change = 1 cycle; last ack to all_halted = 1 cycle.
- Acks from unmasked cores are ignored everywhere.
- Counter saturates; it never wraps.

Decomposition:
- Shared package multicore_debug_pkg:
  - state enum (IDLE=0, HALTING=1, HALTED=2, RESUMING=3);
  - ACK_CNT_W = 8;
  - lowest-set-bit function returning CIDX_W index.
- One natural sub-module: multicore_debug_ack_timer. It is an 8-bit saturating counter with clear/enable and a done flag at ACK_TIMEOUT, reused for both wait states.

Test Plan:
- Host halt, mask=4'b1111, acks rise at cycles 2,3,5,6 after req -> debugreq=1111 cycle 1, all_halted=1 one cycle after 4th ack, halt_cause_host=1, busy low thereafter.
- Sync self-halt: cfg_sync_en=1, mask=1111, core 2 raises debugack -> debugreq=1111 next cycle, halt_cause_host=0, halt_cause_core=2; with cfg_sync_en=0 -> no debugreq change.
- Timeout: mask=0011, only core 0 acks, ACK_TIMEOUT=16 -> timeout_err=1 at 16th HALTING cycle, state HALTED, all_halted=0, debugreq=0011 held.
- Resume: from HALTED, host_resume_req -> debugreq=0000 next cycle, all_halted=0, IDLE one cycle after acks all 0; then a second host_halt_req clears timeout_err.
- Simultaneous host_halt_req and core 1 self-ack in IDLE -> halt_cause_host=1; mask changes during HALTED have no effect until next IDLE.
- reset_n asserted mid-HALTING with debugreq=1111 -> all outputs 0 immediately (async), IDLE after release.
